// File: rtl/l3_output_serializer_if.sv
// Block-side and serial-side signals of the L=3 output serializer.
interface l3_output_serializer_if #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 32,
   parameter int DEPTH     = 4
);
   logic                   flush;
   logic                   blk_valid;
   logic                   blk_ready;
   logic [IN_WIDTH-1:0]    blk_d1;
   logic [IN_WIDTH-1:0]    blk_d2;
   logic [IN_WIDTH-1:0]    blk_d3;
   logic                   ser_valid;
   logic                   ser_ready;
   logic [OUT_WIDTH-1:0]   ser_data;
   logic                   ser_sat;
   logic [$clog2(DEPTH):0] level;

   modport master (
      input  flush, blk_valid, blk_d1, blk_d2, blk_d3, ser_ready,
      output blk_ready, ser_valid, ser_data, ser_sat, level
   );

   modport slave (
      output flush, blk_valid, blk_d1, blk_d2, blk_d3, ser_ready,
      input  blk_ready, ser_valid, ser_data, ser_sat, level
   );
endinterface

// File: rtl/l3_output_serializer.sv
// Buffers 3-sample FIR blocks and replays them as one rescaled sample per clock.
// Optional clamping instead of wrap when L3_SER_SATURATE_EN is defined.
module l3_output_serializer #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 32,
   parameter int SHIFT     = 16,
   parameter int DEPTH     = 4
) (
   input  logic clk,
   input  logic reset_n,
   l3_output_serializer_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {PH_D1 = 2'd0, PH_D2 = 2'd1, PH_D3 = 2'd2} phase_e;

   logic [3*IN_WIDTH-1:0]        mem_q [DEPTH];
   logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                count_q, count_d;
   phase_e                       phase_q, phase_d;
   logic                         ser_valid_q, ser_valid_d;
   logic [OUT_WIDTH-1:0]         ser_data_q, ser_data_d;
   logic                         ser_sat_q, ser_sat_d;

   logic                         push, load, pop;
   logic [3*IN_WIDTH-1:0]        head_blk;
   logic [IN_WIDTH-1:0]          head;
   logic signed [IN_WIDTH-1:0]   shifted;
   logic [OUT_WIDTH-1:0]         scaled;
   logic                         scaled_sat;

   // A pop in the same cycle does not free a slot: ready looks only at count_q.
   assign bus.blk_ready = (count_q != CW'(DEPTH));
   assign push          = bus.blk_valid && bus.blk_ready;
   assign load          = (!ser_valid_q || bus.ser_ready) && (count_q != '0);
   assign pop           = load && (phase_q == PH_D3);

   assign head_blk = mem_q[rd_ptr_q];

   always_comb begin
      head = head_blk[IN_WIDTH-1:0];
      case (phase_q)
         PH_D2:   head = head_blk[2*IN_WIDTH-1:IN_WIDTH];
         PH_D3:   head = head_blk[3*IN_WIDTH-1:2*IN_WIDTH];
         default: head = head_blk[IN_WIDTH-1:0];
      endcase
   end

   assign shifted = $signed(head) >>> SHIFT;

`ifdef L3_SER_SATURATE_EN
   logic in_range;
   // In range when every bit above the output sign bit matches it.
   assign in_range = (shifted[IN_WIDTH-1:OUT_WIDTH-1] ==
                      {(IN_WIDTH-OUT_WIDTH+1){shifted[IN_WIDTH-1]}});

   always_comb begin
      scaled     = shifted[OUT_WIDTH-1:0];
      scaled_sat = 1'b0;
      if (!in_range) begin
         scaled_sat = 1'b1;
         scaled     = shifted[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                          : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end
`else
   logic unused_shift_hi;
   assign unused_shift_hi = ^shifted[IN_WIDTH-1:OUT_WIDTH];
   assign scaled          = shifted[OUT_WIDTH-1:0];
   assign scaled_sat      = 1'b0;
`endif

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      phase_d     = phase_q;
      ser_valid_d = ser_valid_q;
      ser_data_d  = ser_data_q;
      ser_sat_d   = ser_sat_q;

      if (bus.flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         phase_d     = PH_D1;
         ser_valid_d = 1'b0;
         ser_data_d  = '0;
         ser_sat_d   = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (load) begin
            ser_valid_d = 1'b1;
            ser_data_d  = scaled;
            ser_sat_d   = scaled_sat;
            case (phase_q)
               PH_D1:   phase_d = PH_D2;
               PH_D2:   phase_d = PH_D3;
               default: phase_d = PH_D1;
            endcase
            if (pop) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
            end
         end else if (!ser_valid_q || bus.ser_ready) begin
            ser_valid_d = 1'b0;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         phase_q     <= PH_D1;
         ser_valid_q <= 1'b0;
         ser_data_q  <= '0;
         ser_sat_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         phase_q     <= phase_d;
         ser_valid_q <= ser_valid_d;
         ser_data_q  <= ser_data_d;
         ser_sat_q   <= ser_sat_d;
      end
   end

   // Storage needs no reset: only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (push && !bus.flush) begin
         mem_q[wr_ptr_q] <= {bus.blk_d3, bus.blk_d2, bus.blk_d1};
      end
   end

   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_data  = ser_data_q;
   assign bus.ser_sat   = ser_sat_q;
   assign bus.level     = count_q;
endmodule

// File: tb/tb_l3_output_serializer.sv
// Directed bench for l3_output_serializer with hand-computed expected samples.
module tb_l3_output_serializer;
   localparam int IN_WIDTH  = 64;
   localparam int OUT_WIDTH = 32;
   localparam int SHIFT     = 16;
   localparam int DEPTH     = 4;

`ifdef L3_SER_SATURATE_EN
   localparam logic [63:0] SAT1_DATA = 64'h7FFF_FFFF;
   localparam logic [63:0] SAT2_DATA = 64'h7FFF_FFFF;
   localparam logic [63:0] SAT3_DATA = 64'h8000_0000;
   localparam logic [63:0] SAT_FLAG  = 64'd1;
`else
   localparam logic [63:0] SAT1_DATA = 64'h8000_0000;
   localparam logic [63:0] SAT2_DATA = 64'h0000_0000;
   localparam logic [63:0] SAT3_DATA = 64'h0000_0000;
   localparam logic [63:0] SAT_FLAG  = 64'd0;
`endif

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_pass;

   l3_output_serializer_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH)) bus ();

   l3_output_serializer #(
      .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT), .DEPTH(DEPTH)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_blk(input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
      bus.blk_valid = 1'b1;
      bus.blk_d1    = d1;
      bus.blk_d2    = d2;
      bus.blk_d3    = d3;
   endtask

   initial begin
      int n_got;
      int acc_lvl;
      n_chk  = 0;
      n_pass = 0;
      reset_n       = 1'b0;
      bus.flush     = 1'b0;
      bus.blk_valid = 1'b0;
      bus.blk_d1    = '0;
      bus.blk_d2    = '0;
      bus.blk_d3    = '0;
      bus.ser_ready = 1'b1;

      // Reset / idle
      repeat (2) tick();
      check("rst_valid", 64'(bus.ser_valid), 64'd0);
      check("rst_data",  64'(bus.ser_data),  64'd0);
      check("rst_sat",   64'(bus.ser_sat),   64'd0);
      check("rst_level", 64'(bus.level),     64'd0);
      reset_n = 1'b1;
      tick();
      check("rst_ready", 64'(bus.blk_ready), 64'd1);

      // Order and scale
      drive_blk(64'h1_0000, 64'h2_0000, -64'sh3_0000);
      tick();
      bus.blk_valid = 1'b0;
      check("ord_lat_valid", 64'(bus.ser_valid), 64'd0);
      check("ord_lat_level", 64'(bus.level),     64'd1);
      tick();
      check("ord_d1", 64'(bus.ser_data), 64'd1);
      tick();
      check("ord_d2", 64'(bus.ser_data), 64'd2);
      tick();
      check("ord_d3",     64'(bus.ser_data), 64'hFFFF_FFFD);
      check("ord_d3_sat", 64'(bus.ser_sat),  64'd0);
      check("ord_d3_lvl", 64'(bus.level),    64'd0);
      tick();
      check("ord_idle", 64'(bus.ser_valid), 64'd0);

      // Full / backpressure: samples numbered 1..15 in push order
      bus.ser_ready = 1'b0;
      for (int b = 0; b < 5; b++) begin
         drive_blk(64'(b*3+1) << 16, 64'(b*3+2) << 16, 64'(b*3+3) << 16);
         tick();
         if (b < 4) check($sformatf("full_lvl%0d", b), 64'(bus.level), 64'(b+1));
      end
      check("full_level", 64'(bus.level),     64'd4);
      check("full_ready", 64'(bus.blk_ready), 64'd0);
      check("full_hold",  64'(bus.ser_data),  64'd1);
      bus.ser_ready = 1'b1;
      n_got   = 0;
      acc_lvl = -1;
      for (int cyc = 0; cyc < 60 && n_got < 15; cyc++) begin
         if (bus.ser_valid) begin
            check($sformatf("full_s%0d", n_got+1), 64'(bus.ser_data), 64'(n_got+1));
            n_got++;
         end
         if (bus.blk_valid && bus.blk_ready) acc_lvl = int'(bus.level);
         tick();
         if (acc_lvl >= 0) bus.blk_valid = 1'b0;
      end
      check("full_count",   64'(n_got),         64'd15);
      check("full_acc_lvl", 64'(acc_lvl),       64'd3);
      check("full_drain_v", 64'(bus.ser_valid), 64'd0);
      check("full_drain_l", 64'(bus.level),     64'd0);

      // Stall mid-block; d3 = -1 checks floor rounding
      drive_blk(64'hA_0000, 64'hB_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      bus.blk_valid = 1'b0;
      tick();
      check("stall_d1", 64'(bus.ser_data), 64'hA);
      bus.ser_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall_hold%0d", i), 64'(bus.ser_data),  64'hA);
         check($sformatf("stall_vld%0d",  i), 64'(bus.ser_valid), 64'd1);
      end
      bus.ser_ready = 1'b1;
      tick();
      check("stall_d2", 64'(bus.ser_data), 64'hB);
      tick();
      check("stall_d3", 64'(bus.ser_data), 64'hFFFF_FFFF);
      tick();
      check("stall_idle", 64'(bus.ser_valid), 64'd0);

      // Flush with two blocks buffered and a sample pending
      bus.ser_ready = 1'b0;
      drive_blk(64'h14_0000, 64'h15_0000, 64'h16_0000);
      tick();
      drive_blk(64'h17_0000, 64'h18_0000, 64'h19_0000);
      tick();
      bus.blk_valid = 1'b0;
      check("fl_pre_lvl",  64'(bus.level),     64'd2);
      check("fl_pre_data", 64'(bus.ser_data),  64'h14);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("fl_valid", 64'(bus.ser_valid), 64'd0);
      check("fl_level", 64'(bus.level),     64'd0);
      check("fl_ready", 64'(bus.blk_ready), 64'd1);
      bus.ser_ready = 1'b1;
      drive_blk(64'h1E_0000, 64'h1F_0000, 64'h20_0000);
      tick();
      bus.blk_valid = 1'b0;
      tick();
      check("fl_d1", 64'(bus.ser_data), 64'h1E);
      tick();
      check("fl_d2", 64'(bus.ser_data), 64'h1F);
      tick();
      check("fl_d3", 64'(bus.ser_data), 64'h20);
      tick();

      // Reset asserted mid-block
      drive_blk(64'h28_0000, 64'h29_0000, 64'h2A_0000);
      tick();
      bus.blk_valid = 1'b0;
      tick();
      check("mr_d1", 64'(bus.ser_data), 64'h28);
      reset_n = 1'b0;
      #1;
      check("mr_valid", 64'(bus.ser_valid), 64'd0);
      tick();
      reset_n = 1'b1;
      repeat (4) tick();
      check("mr_quiet", 64'(bus.ser_valid), 64'd0);
      check("mr_level", 64'(bus.level),     64'd0);

      // Saturation / wrap
      drive_blk(64'h0000_8000_0000_0000, 64'h0001_0000_0000_0000, 64'hFFFF_0000_0000_0000);
      tick();
      bus.blk_valid = 1'b0;
      tick();
      check("sat_d1",   64'(bus.ser_data), SAT1_DATA);
      check("sat_f1",   64'(bus.ser_sat),  SAT_FLAG);
      tick();
      check("sat_d2",   64'(bus.ser_data), SAT2_DATA);
      tick();
      check("sat_d3",   64'(bus.ser_data), SAT3_DATA);
      check("sat_f3",   64'(bus.ser_sat),  SAT_FLAG);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
